// File: rtl/seq_pkg.sv
// Shared widths, FSM state encodings and slot helper for the Sequencer byte collector.
package seq_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    localparam int CNT_W      = $clog2(WORD_BYTES);
    localparam int BCNT_W     = $clog2(WORD_BYTES + 1);
    localparam int FIFO_W     = BCNT_W + WORD_W;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_FLUSH   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;

    // Slot 0 is the most significant byte of the packed word.
    function automatic int slot_lsb(input logic [CNT_W-1:0] slot);
        return (WORD_BYTES - 1 - int'(slot)) * BYTE_W;
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// First-word-fall-through FIFO; head is visible whenever non-empty and reads 0 when empty.
module seq_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/seq_collector.sv
// Packs Sequencer bytes MSB-first into words, flushes partial words on Seq_done,
// and hands them to the next stage through an output FIFO.
module seq_collector
    import seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Seq_en,
    input  logic              Seq_done,
    input  logic [BYTE_W-1:0] Sequence,
    output logic [WORD_W-1:0] out_data,
    output logic [BCNT_W-1:0] out_bytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              frame_done
);

    logic [2:0]        state;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] pack;
    logic [WORD_W-1:0] pack_next;
    logic              push_pend;
    logic              cap;
    logic              last;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [BCNT_W-1:0] push_bytes;
    logic [FIFO_W-1:0] fifo_out;

    assign cap        = Seq_en & ~Seq_done & ((state == ST_IDLE) | (state == ST_COLLECT));
    assign last       = (count == CNT_W'(WORD_BYTES - 1));
    assign push       = push_pend | ((state == ST_FLUSH) && (count != '0));
    assign push_bytes = push_pend ? BCNT_W'(WORD_BYTES) : BCNT_W'(count);

    // Output handshake: a word transfers on a rising edge where out_valid and out_ready
    // are both high; out_data/out_bytes hold the head word for as long as out_valid is high.
    assign out_valid  = ~empty;
    assign pop        = out_valid & out_ready;
    assign out_bytes  = fifo_out[FIFO_W-1:WORD_W];
    assign out_data   = fifo_out[WORD_W-1:0];

    // Starting a new word clears the stale lower slots so partial words are zero-padded.
    always_comb begin
        pack_next = (count == '0) ? '0 : pack;
        pack_next[slot_lsb(count) +: BYTE_W] = Sequence;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            pack       <= '0;
            push_pend  <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            push_pend  <= cap & last;
            if (push & full & ~pop) overflow <= 1'b1;
            if (cap) begin
                pack  <= pack_next;
                count <= count + CNT_W'(1);
            end
            case (state)
                ST_IDLE:    if (cap) state <= ST_COLLECT;
                ST_COLLECT: if (Seq_done) state <= ST_FLUSH;
                ST_FLUSH: begin
                    count <= '0;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (empty) begin
                        frame_done <= 1'b1;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT:    if (~Seq_en & ~Seq_done) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    seq_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_bytes, pack}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_seq_collector.sv
// Scoreboard bench for seq_collector: byte-level model predicts words, FIFO drops and frame_done.
module tb_seq_collector;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        Seq_en;
    logic        Seq_done;
    logic [7:0]  Sequence;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        frame_done;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          fd_count = 0;
    logic [34:0] exp_q[$];
    logic [34:0] pend_word;
    bit          pend_valid = 0;
    bit          exp_ovf    = 0;
    bit          rand_ready = 0;
    logic [34:0] last_word  = '0;
    logic [31:0] m_pack     = '0;
    int          m_cnt      = 0;

    seq_collector #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .Seq_en     (Seq_en),
        .Seq_done   (Seq_done),
        .Sequence   (Sequence),
        .out_data   (out_data),
        .out_bytes  (out_bytes),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: compare handshake and head word, then apply this cycle's push to the model FIFO.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", out_valid, exp_q.size() != 0);
            if (!out_valid) check("empty_zero", {out_bytes, out_data}, 0);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                last_word = exp_q.pop_front();
                check("word", {out_bytes, out_data}, last_word);
            end
            if (pend_valid) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(pend_word);
                else exp_ovf = 1;
                pend_valid = 0;
            end
            if (frame_done) fd_count++;
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        tick(1);
        rst = 0;
        exp_q.delete();
        pend_valid = 0;
        exp_ovf = 0;
        m_cnt = 0;
        m_pack = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        Seq_en = 1;
        Sequence = b;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        tick(1);
        Seq_en = 0;
        if (m_cnt == 0) m_pack = '0;
        m_pack[(3 - m_cnt) * 8 +: 8] = b;
        m_cnt++;
        if (m_cnt == 4) begin
            pend_word = {3'd4, m_pack};
            pend_valid = 1;
            m_cnt = 0;
        end
    endtask

    task automatic finish_frame();
        int start;
        bit got;
        start = fd_count;
        got = 0;
        out_ready = 1;
        Seq_en = 0;
        Seq_done = 1;
        tick(1);
        if (m_cnt > 0) begin
            pend_word = {3'(m_cnt), m_pack};
            pend_valid = 1;
            m_cnt = 0;
        end
        for (int i = 0; i < 100 && !got; i++) begin
            tick(1);
            if (fd_count != start) got = 1;
        end
        check("frame_done_seen", got, 1);
        Seq_done = 0;
        tick(3);
        check("frame_done_once", fd_count - start, 1);
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int fd0;
        rst = 1;
        Seq_en = 0;
        Seq_done = 0;
        Sequence = '0;
        out_ready = 1;
        tick(2);
        rst = 0;

        check("rst_valid", out_valid, 0);
        check("rst_data", {out_bytes, out_data}, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_done", frame_done, 0);

        // Seq_done in IDLE does nothing
        fd0 = fd_count;
        Seq_done = 1;
        tick(2);
        Seq_done = 0;
        tick(3);
        check("idle_done_fd", fd_count, fd0);

        // One full word, latency 1 after the 4th byte
        send_byte(8'hab); send_byte(8'hcd); send_byte(8'hef); send_byte(8'hab);
        check("lat_before", out_valid, 0);
        tick(1);
        check("lat_after", out_valid, 1);
        finish_frame();
        check("t1_word", last_word, {3'd4, 32'habcdefab});

        // Full word followed by a 2-byte partial
        for (int i = 1; i <= 6; i++) send_byte(8'(i * 8'h11));
        finish_frame();
        check("t2_word", last_word, {3'd2, 32'h55660000});

        // Pause in the middle of a word
        send_byte(8'h5a); send_byte(8'hc3);
        tick(3);
        send_byte(8'h96); send_byte(8'h0f);
        finish_frame();
        check("t5_word", last_word, {3'd4, 32'h5ac3960f});

        // Overflow: five words into a four-entry FIFO
        out_ready = 0;
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        tick(2);
        check("ovf_model", exp_ovf, 1);
        check("ovf_set", overflow, exp_ovf);
        check("ovf_head", {out_bytes, out_data}, {3'd4, 32'h00010203});
        finish_frame();
        check("ovf_last", last_word, {3'd4, 32'h0c0d0e0f});
        check("ovf_sticky", overflow, 1);

        // Full FIFO with simultaneous pop and push
        do_reset();
        check("rst2_overflow", overflow, 0);
        out_ready = 0;
        for (int i = 0; i < 20; i++) send_byte(8'(8'h40 + i));
        out_ready = 1;
        tick(1);
        out_ready = 0;
        tick(1);
        check("pushpop_ovf", overflow, 0);
        check("pushpop_model", exp_ovf, 0);
        finish_frame();
        check("pushpop_last", last_word, {3'd4, 32'h50515253});

        // Reset mid-frame discards the partial word
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        fd0 = fd_count;
        do_reset();
        check("midrst_valid", out_valid, 0);
        check("midrst_fd", fd_count, fd0);
        send_byte(8'haa); send_byte(8'hbb); send_byte(8'hcc); send_byte(8'hdd);
        finish_frame();
        check("midrst_word", last_word, {3'd4, 32'haabbccdd});

        // Random frames with random back-pressure
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 11);
            rand_ready = 1;
            for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
            rand_ready = 0;
            finish_frame();
        end
        check("rand_overflow", overflow, exp_ovf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
